isa_io_arbiter: RTL and testbench

ISA_IO_ARBITER -- requirements
Module: isa_io_arbiter

---
 rtl/isa_io_arbiter.sv | 147 ++++++++++++++
 tb/tb_isa_io_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/isa_io_arbiter.sv
// Four-requester round-robin arbiter driving ISA I/O read/write cycles.
// Optional macro ISA_IOCHRDY_EN adds iochrdy wait states with a WAIT_MAX timeout.
module isa_io_arbiter #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 8,
  parameter int HOLD_CYCLES   = 2,
  parameter int WAIT_MAX      = 64
) (
  input  logic        sys_clock,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [3:0]  req_wr,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [15:0] rdata,
  output logic        timeout,
  output logic [15:0] address,
  output logic [15:0] data_out,
  input  logic [15:0] data_in,
  output logic        data_dir,
  output logic        ior_n,
  output logic        iow_n,
  input  logic        iochrdy
);

  localparam int M1 = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int M2 = (M1 > HOLD_CYCLES) ? M1 : HOLD_CYCLES;
  localparam int MC = (M2 > WAIT_MAX) ? M2 : WAIT_MAX;
  localparam int CW = $clog2(MC + 1);

`ifdef ISA_IOCHRDY_EN
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  logic unused_iochrdy;
  assign unused_iochrdy = iochrdy;
`endif

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    sel;
  logic [1:0]    pick;
  logic          wr_l;
  logic          tflag;
  logic [CW-1:0] cnt;

  // Descending scan so the lowest offset from ptr wins.
  always_comb begin
    pick = ptr;
    for (int j = 3; j >= 0; j--) begin
      if (req[ptr + 2'(j)]) pick = ptr + 2'(j);
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      sel      <= 2'd0;
      wr_l     <= 1'b0;
      tflag    <= 1'b0;
      cnt      <= '0;
      grant    <= 4'd0;
      done     <= 4'd0;
      timeout  <= 1'b0;
      rdata    <= 16'd0;
      address  <= 16'd0;
      data_out <= 16'd0;
      data_dir <= 1'b0;
      ior_n    <= 1'b1;
      iow_n    <= 1'b1;
    end else begin
      done    <= 4'd0;
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            sel      <= pick;
            wr_l     <= req_wr[pick];
            address  <= req_addr[16*pick +: 16];
            data_out <= req_wdata[16*pick +: 16];
            data_dir <= req_wr[pick];
            grant    <= 4'd1 << pick;
            tflag    <= 1'b0;
            cnt      <= CW'(SETUP_CYCLES - 1);
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt   <= CW'(STROBE_CYCLES - 1);
            ior_n <= wr_l;
            iow_n <= !wr_l;
            state <= STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
`ifdef ISA_IOCHRDY_EN
          end else if (!iochrdy) begin
            cnt   <= CW'(WAIT_MAX - 1);
            state <= WAIT;
`endif
          end else begin
            if (!wr_l) rdata <= data_in;
            ior_n <= 1'b1;
            iow_n <= 1'b1;
            cnt   <= CW'(HOLD_CYCLES - 1);
            state <= HOLD;
          end
        end
`ifdef ISA_IOCHRDY_EN
        WAIT: begin
          if (iochrdy || cnt == '0) begin
            if (!wr_l) rdata <= iochrdy ? data_in : 16'hFFFF;
            tflag <= !iochrdy;
            ior_n <= 1'b1;
            iow_n <= 1'b1;
            cnt   <= CW'(HOLD_CYCLES - 1);
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        HOLD: begin
          if (cnt == '0) begin
            done    <= 4'd1 << sel;
            timeout <= tflag;
            grant   <= 4'd0;
            ptr     <= sel + 2'd1;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isa_io_arbiter.sv
// Directed bench for isa_io_arbiter: latency, strobes, round-robin, async reset.
// ISA_IOCHRDY_EN builds also exercise wait states and timeout.
module tb_isa_io_arbiter;

  logic        sys_clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req, req_wr, grant, done;
  logic [63:0] req_addr, req_wdata;
  logic [15:0] rdata, address, data_out, data_in;
  logic        timeout, data_dir, ior_n, iow_n, iochrdy;

  int checks = 0;
  int errors = 0;

  always #5 sys_clock = ~sys_clock;

  isa_io_arbiter dut (
    .sys_clock(sys_clock), .reset_n(reset_n),
    .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .done(done), .rdata(rdata),
    .timeout(timeout), .address(address),
    .data_out(data_out), .data_in(data_in),
    .data_dir(data_dir), .ior_n(ior_n),
    .iow_n(iow_n), .iochrdy(iochrdy)
  );

  // Measures one transfer; req must already be driven before the sampling edge.
  // chrdy_lo: iochrdy held low from n=1 until n==chrdy_lo (0 = never low).
  task automatic run_xfer(
    input  logic [15:0] ea, input logic [15:0] ew,
    input  logic ed, input bit drop, input int chrdy_lo,
    output int lat, output logic [3:0] g1,
    output logic [3:0] dn, output logic [3:0] gd,
    output int rd, output int wr,
    output int both, output int mism, output logic to
  );
    int n;
    if (chrdy_lo != 0) iochrdy = 1'b0;
    @(negedge sys_clock);
    n = 1; g1 = grant;
    rd = 0; wr = 0; both = 0; mism = 0;
    while (done == 4'd0 && n < 300) begin
      if (drop && n == 2) begin
        req = 4'd0; req_addr = ~req_addr;
        req_wdata = ~req_wdata; req_wr = ~req_wr;
      end
      if (chrdy_lo != 0 && n == chrdy_lo) iochrdy = 1'b1;
      if (!ior_n) rd++;
      if (!iow_n) wr++;
      if (!ior_n && !iow_n) both++;
      if (address !== ea || data_dir !== ed ||
          (ed && data_out !== ew)) mism++;
      @(negedge sys_clock);
      n++;
    end
    lat = (done != 4'd0) ? n : -1;
    dn = done; gd = grant; to = timeout;
    iochrdy = 1'b1;
    req = 4'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
    data_in = 16'h0000; iochrdy = 1'b1;
    repeat (2) @(negedge sys_clock);
    checks++;
    if ({grant, done, timeout, ior_n, iow_n, data_dir} !== 12'b0000_0000_0110) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 000000000110",
               {grant, done, timeout, ior_n, iow_n, data_dir});
    end
    checks++;
    if ({rdata, address, data_out} !== 48'd0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {rdata, address, data_out});
    end
    reset_n = 1'b1;
    @(negedge sys_clock);
  endtask

  task automatic test_read();
    int lat, rd, wr, both, mism; logic [3:0] g1, dn, gd; logic to;
    req_addr[15:0] = 16'h0226; req_wr = 4'b0000;
    data_in = 16'h00AA; req = 4'b0001;
    run_xfer(16'h0226, 16'h0, 1'b0, 0, 0, lat, g1, dn, gd, rd, wr, both, mism, to);
    checks++;
    if (g1 !== 4'b0001) begin errors++; $display("FAIL rd_grant: got %b want 0001", g1); end
    checks++;
    if (lat !== 13) begin errors++; $display("FAIL rd_latency: got %0d want 13", lat); end
    checks++;
    if (rd !== 8 || wr !== 0) begin
      errors++; $display("FAIL rd_strobe: ior low %0d iow low %0d want 8/0", rd, wr);
    end
    checks++;
    if (dn !== 4'b0001 || gd !== 4'b0000) begin
      errors++; $display("FAIL rd_done: done %b grant %b want 0001/0000", dn, gd);
    end
    checks++;
    if (rdata !== 16'h00AA || mism !== 0 || to !== 1'b0) begin
      errors++; $display("FAIL rd_data: rdata %h mism %0d to %b want 00aa/0/0", rdata, mism, to);
    end
  endtask

  task automatic test_write();
    int lat, rd, wr, both, mism; logic [3:0] g1, dn, gd; logic to;
    req_addr[47:32] = 16'h0246; req_wdata[47:32] = 16'h0001;
    req_wr = 4'b0100; data_in = 16'h5555; req = 4'b0100;
    run_xfer(16'h0246, 16'h0001, 1'b1, 0, 0, lat, g1, dn, gd, rd, wr, both, mism, to);
    checks++;
    if (g1 !== 4'b0100 || lat !== 13) begin
      errors++; $display("FAIL wr_grant_lat: grant %b lat %0d want 0100/13", g1, lat);
    end
    checks++;
    if (wr !== 8 || rd !== 0) begin
      errors++; $display("FAIL wr_strobe: iow low %0d ior low %0d want 8/0", wr, rd);
    end
    checks++;
    if (mism !== 0) begin errors++; $display("FAIL wr_bus: %0d bad cycles want 0", mism); end
    checks++;
    if (dn !== 4'b0100 || rdata !== 16'h00AA) begin
      errors++; $display("FAIL wr_done_rdata: done %b rdata %h want 0100/00aa", dn, rdata);
    end
  endtask

  task automatic test_async_reset();
    int n; int saw_done;
    int lat, rd, wr, both, mism; logic [3:0] g1, dn, gd; logic to;
    req_wr = 4'b0000; req = 4'b0010; saw_done = 0; n = 0;
    while (ior_n !== 1'b0 && n < 20) begin @(negedge sys_clock); n++; end
    repeat (3) @(negedge sys_clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ior_n !== 1'b1 || iow_n !== 1'b1 || grant !== 4'd0) begin
      errors++; $display("FAIL async_rst: ior %b iow %b grant %b want 1/1/0000", ior_n, iow_n, grant);
    end
    req = 4'b0000;
    repeat (2) begin @(negedge sys_clock); if (done != 0) saw_done++; end
    reset_n = 1'b1;
    repeat (15) begin @(negedge sys_clock); if (done != 0) saw_done++; end
    checks++;
    if (saw_done !== 0) begin errors++; $display("FAIL rst_no_done: %0d pulses want 0", saw_done); end
    req_addr[15:0] = 16'h0100; data_in = 16'h1234; req = 4'b1001;
    run_xfer(16'h0100, 16'h0, 1'b0, 0, 0, lat, g1, dn, gd, rd, wr, both, mism, to);
    checks++;
    if (g1 !== 4'b0001 || dn !== 4'b0001 || rdata !== 16'h1234) begin
      errors++; $display("FAIL rst_ptr: grant %b done %b rdata %h want 0001/0001/1234", g1, dn, rdata);
    end
  endtask

  task automatic test_mid_change();
    int lat, rd, wr, both, mism; logic [3:0] g1, dn, gd; logic to;
    req_addr[63:48] = 16'h0300; req_wdata = 64'd0;
    req_wr = 4'b0000; data_in = 16'hBEEF; req = 4'b1000;
    run_xfer(16'h0300, 16'h0, 1'b0, 1, 0, lat, g1, dn, gd, rd, wr, both, mism, to);
    checks++;
    if (g1 !== 4'b1000 || lat !== 13 || dn !== 4'b1000) begin
      errors++; $display("FAIL drop_done: grant %b lat %0d done %b want 1000/13/1000", g1, lat, dn);
    end
    checks++;
    if (mism !== 0 || rd !== 8 || wr !== 0 || rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL drop_bus: mism %0d rd %0d wr %0d rdata %h want 0/8/0/beef", mism, rd, wr, rdata);
    end
    req_addr = 64'd0; req_wr = 4'b0000; req_wdata = 64'd0;
  endtask

  task automatic test_contention();
    logic [3:0] order [5];
    int multi, n;
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    multi = 0; req_wr = 4'b0000; req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      @(negedge sys_clock); n = 0;
      while (grant == 4'd0 && n < 20) begin @(negedge sys_clock); n++; end
      checks++;
      if (grant !== order[t]) begin
        errors++; $display("FAIL rr_grant%0d: got %b want %b", t, grant, order[t]);
      end
      n = 0;
      while (done == 4'd0 && n < 40) begin
        if (!$onehot0(grant)) multi++;
        @(negedge sys_clock); n++;
      end
      if (t == 4) req = 4'd0;
      checks++;
      if (done !== order[t]) begin
        errors++; $display("FAIL rr_done%0d: got %b want %b", t, done, order[t]);
      end
    end
    checks++;
    if (multi !== 0) begin errors++; $display("FAIL rr_onehot: %0d bad cycles want 0", multi); end
    repeat (3) @(negedge sys_clock);
  endtask

`ifdef ISA_IOCHRDY_EN
  task automatic test_iochrdy();
    int lat, rd, wr, both, mism; logic [3:0] g1, dn, gd; logic to;
    req_addr[15:0] = 16'h0226; data_in = 16'h0042; req = 4'b0001;
    run_xfer(16'h0226, 16'h0, 1'b0, 0, 15, lat, g1, dn, gd, rd, wr, both, mism, to);
    checks++;
    if (lat !== 18 || rd !== 13 || to !== 1'b0 || rdata !== 16'h0042) begin
      errors++; $display("FAIL wait5: lat %0d rd %0d to %b rdata %h want 18/13/0/0042", lat, rd, to, rdata);
    end
    req = 4'b0001;
    run_xfer(16'h0226, 16'h0, 1'b0, 0, 999, lat, g1, dn, gd, rd, wr, both, mism, to);
    checks++;
    if (lat !== 13 + 64 || to !== 1'b1 || rdata !== 16'hFFFF) begin
      errors++; $display("FAIL wait_to: lat %0d to %b rdata %h want 77/1/ffff", lat, to, rdata);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_async_reset();
    test_mid_change();
    test_contention();
`ifdef ISA_IOCHRDY_EN
    test_iochrdy();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
